// File: rtl/sram_burst_ctrl_if.sv
// rtl/sram_burst_ctrl_if.sv - request/write-data/response and SRAM pin bundle for sram_burst_ctrl
interface sram_burst_ctrl_if #(
  parameter int ADR  = 8,
  parameter int DAT  = 8,
  parameter int LENW = 4
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [ADR-1:0]  req_addr;
  logic [LENW-1:0] req_len;
  logic            wd_valid;
  logic            wd_ready;
  logic [DAT-1:0]  wd_data;
  logic            rsp_valid;
  logic [DAT-1:0]  rsp_data;
  logic            rsp_last;
  logic            err;
  logic            mem_cs;
  logic            mem_we;
  logic            mem_rd;
  logic [ADR-1:0]  mem_addr;
  logic [DAT-1:0]  mem_din;
  logic [DAT-1:0]  mem_dout;

  modport master (
    output req_valid, req_write, req_addr, req_len, wd_valid, wd_data, mem_dout,
    input  req_ready, wd_ready, rsp_valid, rsp_data, rsp_last, err,
           mem_cs, mem_we, mem_rd, mem_addr, mem_din
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wd_valid, wd_data, mem_dout,
    output req_ready, wd_ready, rsp_valid, rsp_data, rsp_last, err,
           mem_cs, mem_we, mem_rd, mem_addr, mem_din
  );
endinterface

// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - burst initiator for a single-port synchronous SRAM
module sram_burst_ctrl #(
  parameter int ADR  = 8,
  parameter int DAT  = 8,
  parameter int DPTH = 8,
  parameter int LENW = 4
) (
  input logic              clk,
  input logic              rst,
  sram_burst_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  localparam logic [ADR:0]   DPTH_L   = (ADR+1)'(DPTH);
  localparam logic [ADR-1:0] ADDR_MAX = ADR'(DPTH - 1);

  state_t          r_state;
  logic [ADR-1:0]  r_cur_addr;
  logic [LENW-1:0] r_beats_left;
  logic            r_rd_pend;
  logic            r_rd_last_pend;
  logic            r_err;

  logic            w_idle;
  logic            w_wr_st;
  logic            w_rd_st;
  logic            w_addr_bad;
  logic            w_wr_beat;
  logic            w_last;
  logic [ADR-1:0]  w_next_addr;

  assign w_idle      = (r_state == S_IDLE);
  assign w_wr_st     = (r_state == S_WRITE);
  assign w_rd_st     = (r_state == S_READ);
  assign w_addr_bad  = ({1'b0, bus.req_addr} >= DPTH_L);
  assign w_wr_beat   = w_wr_st && bus.wd_valid;
  assign w_last      = (r_beats_left == '0);
  // Explicit wrap so non-power-of-2 depths never address past the last word
  assign w_next_addr = (r_cur_addr == ADDR_MAX) ? '0 : r_cur_addr + ADR'(1);

  assign bus.req_ready = w_idle;
  assign bus.wd_ready  = w_wr_st;
  assign bus.mem_we    = w_wr_beat;
  assign bus.mem_rd    = w_rd_st;
  assign bus.mem_cs    = w_wr_beat || w_rd_st;
  assign bus.mem_addr  = r_cur_addr;
  assign bus.mem_din   = w_wr_st ? bus.wd_data : '0;
  assign bus.rsp_valid = r_rd_pend;
  assign bus.rsp_data  = bus.mem_dout;
  assign bus.rsp_last  = r_rd_last_pend;
  assign bus.err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cur_addr     <= '0;
      r_beats_left   <= '0;
      r_rd_pend      <= 1'b0;
      r_rd_last_pend <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_err          <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_rd_last_pend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (w_addr_bad) begin
              r_err <= 1'b1;
            end else begin
              r_cur_addr   <= bus.req_addr;
              r_beats_left <= bus.req_len;
              r_state      <= bus.req_write ? S_WRITE : S_READ;
            end
          end
        end
        S_WRITE: begin
          if (bus.wd_valid) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_beats_left <= r_beats_left - LENW'(1);
              r_cur_addr   <= w_next_addr;
            end
          end
        end
        S_READ: begin
          // The SRAM registers its output, so the response trails the issued beat by one cycle
          r_rd_pend      <= 1'b1;
          r_rd_last_pend <= w_last;
          if (w_last) begin
            r_state <= S_IDLE;
          end else begin
            r_beats_left <= r_beats_left - LENW'(1);
            r_cur_addr   <= w_next_addr;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
- Initiator-side controller for the team's single-port synchronous SRAM.
- Accepts read and write burst requests over a valid/ready handshake.
- Drives the SRAM strobes (CS, WE, RD), address and write data one beat per cycle.
- Returns read data with fixed latency; lets datapath blocks use the SRAM without hand-sequencing its strobes.

Parameters:
- ADR, 8, address width.
- DAT, 8, data width.
- DPTH, 8, number of SRAM words; valid addresses are 0..DPTH-1.
- LENW, 4, width of the burst-length field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADR  start address.
- req_len  in  LENW  burst beats minus 1.
- wd_valid  in  1  write-data beat valid.
- wd_ready  out  1  controller consumes a write beat.
- wd_data  in  DAT  write-data beat.
- rsp_valid  out  1  read data valid.
- rsp_data  out  DAT  read data.
- rsp_last  out  1  final beat of a read burst.
- err  out  1  one-cycle pulse: request rejected.
- mem_cs  out  1  SRAM chip select.
- mem_we  out  1  SRAM write enable.
- mem_rd  out  1  SRAM read enable.
- mem_addr  out  ADR  SRAM address.
- mem_din  out  DAT  SRAM write data.
- mem_dout  in  DAT  SRAM registered read data.

Behaviour:
- States: IDLE, WRITE, READ. Registers: cur_addr, beats_left, rd_pend, rd_last_pend.
- Reset (rst=1 at posedge):
  - State -> IDLE; cur_addr=0, beats_left=0, rd_pend=0, rd_last_pend=0, err=0.
  - Visible outputs after reset: req_ready=1, wd_ready=0, mem_cs=mem_we=mem_rd=0, mem_addr=0, mem_din=0, rsp_valid=0, rsp_last=0.
  - Reset mid-burst aborts the burst: no further strobes, and any pending response is dropped.
- IDLE:
  - req_ready=1; all strobes 0.
  - Handshake = req_valid && req_ready at posedge.
  - If req_addr >= DPTH: err=1 for the next cycle, stay IDLE, no SRAM access.
  - Otherwise: cur_addr=req_addr, beats_left=req_len, go to WRITE or READ per req_write.
- WRITE:
  - wd_ready=1, req_ready=0.
  - mem_cs=mem_we=wd_valid, mem_rd=0, mem_addr=cur_addr, mem_din=wd_data (combinational).
  - wd_valid=0 is a stall cycle: no strobes, counters hold.
  - On each consumed beat: if beats_left==0, go to IDLE; else decrement beats_left and advance cur_addr.
- READ:
  - mem_cs=mem_rd=1, mem_we=0, mem_addr=cur_addr, one beat per cycle, never stalls.
  - Each issued beat sets rd_pend=1 for the next cycle; rd_last_pend is set when beats_left==0.
  - After the last beat, go to IDLE.
- Response path:
  - rsp_valid=rd_pend, rsp_data=mem_dout, rsp_last=rd_last_pend.
  - Beat issued in cycle N is returned in cycle N+1, so latency from request handshake (cycle T) to first rsp_valid is 2 cycles (cycle T+2).
- Address advance: cur_addr wraps from DPTH-1 to 0, including non-power-of-2 DPTH. Bursts longer than DPTH revisit addresses.
- Back-to-back requests:
  - A new request may be accepted in the IDLE cycle following a burst's final beat.
  - The prior read's last response overlaps that IDLE cycle without conflict.
  - Minimum gap between bursts is 1 IDLE cycle.
- In IDLE, mem_addr holds cur_addr, mem_din=0, strobes 0.
- mem_we and mem_rd are never both 1; mem_cs=0 whenever both are 0.
- No X on any output after reset.

Test Plan:
- Write 1 beat: addr=3, data 0xA5, then read 1 beat at addr=3.
  - Required: mem_cs/mem_we high 1 cycle with mem_addr=3, mem_din=0xA5.
  - Required: rsp_valid at T+2 with rsp_data=0xA5, rsp_last=1.
- Write burst: addr=0, len=3, data 0x10..0x13, with wd_valid low for 2 cycles after the 2nd beat.
  - Required: exactly 4 write strobes at addresses 0,1,2,3 and no strobes during the stall.
  - Required: a following read of addr=0, len=3 returns 0x10,0x11,0x12,0x13 on consecutive cycles, rsp_last on the 4th beat.
- Wrap: read addr=6, len=3 with DPTH=8.
  - Required: mem_addr sequence 6,7,0,1; 4 responses; rsp_last on the 4th.
- Out of range: req_addr=9, DPTH=8.
  - Required: err=1 for one cycle; mem_cs stays 0; req_ready stays 1.
- Reset mid-burst: read addr=0, len=7, rst asserted after 3 beats issued.
  - Required: next cycle strobes 0, rsp_valid=0, req_ready=1; no further responses.
- Back-to-back: write burst (len=1) immediately followed by a read request.
  - Required: read accepted in the single IDLE cycle after the last write beat; first rsp_valid 2 cycles after acceptance.
